// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
// Holds the FSM state type, accumulator sizing and output saturation.
package fir_pkg;

   typedef enum logic {IDLE, MAC} fir_state_t;

   function automatic int acc_width(input int dw, input int cw, input int nt);
      return dw + cw + $clog2(nt) + 1;
   endfunction

   // Returns {clamped, value}; value is the clamped input in 64-bit form.
   function automatic logic [64:0] sat(
      input logic signed [63:0] v,
      input int                 ow,
      input logic               sgn
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      if (sgn) begin
         hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
         lo = -(64'sd1 <<< (ow - 1));
      end else begin
         hi = (64'sd1 <<< ow) - 64'sd1;
         lo = '0;
      end
      if (v > hi) return {1'b1, hi};
      if (v < lo) return {1'b1, lo};
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/fir_filter_mac_coef_bank.sv
// Coefficient register file for the FIR filter: reset-to-1 taps,
// a guarded write port with a drop pulse, and a combinational tap read.
module fir_coef_bank
   import fir_pkg::*;
#(
   parameter int N_TAPS = 8,
   parameter int COEF_W = 8,
   parameter int AW     = $clog2(N_TAPS)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_we,
   input  logic [AW-1:0]     i_addr,
   input  logic [COEF_W-1:0] i_data,
   input  logic              i_busy,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [COEF_W-1:0] o_rd_data,
   output logic              o_drop
);

   logic [COEF_W-1:0] c_q [N_TAPS];
   logic [COEF_W-1:0] c_d [N_TAPS];
   logic              drop_q;
   logic              drop_d;
   logic              addr_ok;

   always_comb begin
      c_d     = c_q;
      addr_ok = {1'b0, i_addr} < (AW + 1)'(N_TAPS);
      drop_d  = i_we & (i_busy | ~addr_ok);
      if (i_we & ~i_busy & addr_ok) begin
         c_d[i_addr] = i_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < N_TAPS; i++) begin
            c_q[i] <= COEF_W'(1);
         end
         drop_q <= 1'b0;
      end else begin
         c_q    <= c_d;
         drop_q <= drop_d;
      end
   end

   assign o_rd_data = c_q[i_rd_addr];
   assign o_drop    = drop_q;

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR filter: one multiply-accumulate per clock,
// valid/ready sample intake, runtime coefficients and saturated output.
module fir_filter_mac
   import fir_pkg::*;
#(
   parameter int DATA_W = 3,
   parameter int COEF_W = 8,
   parameter int N_TAPS = 8,
   parameter int OUT_W  = 12,
   parameter int SIGNED = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_clear,
   input  logic [DATA_W-1:0]         i_x,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic                      i_coef_we,
   input  logic [$clog2(N_TAPS)-1:0] i_coef_addr,
   input  logic [COEF_W-1:0]         i_coef_data,
   output logic                      o_coef_drop,
   output logic [OUT_W-1:0]          o_y,
   output logic                      o_valid,
   output logic                      o_sat
);

   localparam int KW    = $clog2(N_TAPS);
   localparam int ACC_W = acc_width(DATA_W, COEF_W, N_TAPS);
   localparam logic SGN = (SIGNED != 0);

   fir_state_t        state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] x_q [N_TAPS];
   logic [DATA_W-1:0] x_d [N_TAPS];
   logic [OUT_W-1:0]  y_q, y_d;
   logic              sat_q, sat_d;
   logic              valid_q, valid_d;

   logic [COEF_W-1:0] c_k;
   logic [DATA_W-1:0] x_k;
   logic [ACC_W-1:0]  xe, ce, prod, sum;
   logic [63:0]       sum64;
   logic [64:0]       sat_r;

   fir_coef_bank #(
      .N_TAPS (N_TAPS),
      .COEF_W (COEF_W),
      .AW     (KW)
   ) u_coef (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_we      (i_coef_we),
      .i_addr    (i_coef_addr),
      .i_data    (i_coef_data),
      .i_busy    (state_q == MAC),
      .i_rd_addr (k_q),
      .o_rd_data (c_k),
      .o_drop    (o_coef_drop)
   );

   // Operands are widened to ACC_W first so the truncated product is exact.
   always_comb begin
      x_k   = x_q[k_q];
      xe    = {{(ACC_W - DATA_W){SGN & x_k[DATA_W-1]}}, x_k};
      ce    = {{(ACC_W - COEF_W){SGN & c_k[COEF_W-1]}}, c_k};
      prod  = xe * ce;
      sum   = acc_q + prod;
      sum64 = {{(64 - ACC_W){SGN & sum[ACC_W-1]}}, sum};
      sat_r = sat(sum64, OUT_W, SGN);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      sat_d   = sat_q;
      valid_d = 1'b0;
      if (i_clear) begin
         for (int i = 0; i < N_TAPS; i++) begin
            x_d[i] = '0;
         end
         acc_d   = '0;
         k_d     = '0;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (i_valid) begin
                  for (int i = N_TAPS - 1; i > 0; i--) begin
                     x_d[i] = x_q[i-1];
                  end
                  x_d[0]  = i_x;
                  acc_d   = '0;
                  k_d     = '0;
                  state_d = MAC;
               end
            end
            MAC: begin
               acc_d = sum;
               k_d   = k_q + KW'(1);
               if (k_q == KW'(N_TAPS - 1)) begin
                  y_d     = sat_r[OUT_W-1:0];
                  sat_d   = sat_r[64];
                  valid_d = 1'b1;
                  k_d     = '0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         for (int i = 0; i < N_TAPS; i++) begin
            x_q[i] <= '0;
         end
         y_q     <= '0;
         sat_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sat_q   <= sat_d;
         valid_q <= valid_d;
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_y     = y_q;
   assign o_valid = valid_q;
   assign o_sat   = sat_q;

endmodule
